// File: rtl/bit_window_scanner.sv
//==============================================================================
// bit_window_scanner: serial sliding-window front end for the comparator stage.
// Optional `BIT_WINDOW_SCANNER_OVERLAP_EN enables overlapping matches.  Rev 1.0
//==============================================================================
`default_nettype none

module bit_window_scanner #(
  parameter int LENGTH = 22,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              in_bit,
  input  logic              pat_load,
  input  logic [LENGTH-1:0] pat_data,
  output logic [LENGTH-1:0] cmp_a,
  output logic [LENGTH-1:0] cmp_b,
  input  logic              cmp_eq,
  output logic              match,
  output logic [CNT_W-1:0]  match_count,
  output logic              scanning
);

  localparam int FILL_W = $clog2(LENGTH + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FILL = 2'd1,
    SCAN = 2'd2
  } state_t;

  state_t              state, state_nxt;
  logic [LENGTH-1:0]   window, window_nxt;
  logic [LENGTH-1:0]   pattern, pattern_nxt;
  logic [FILL_W-1:0]   fill_cnt, fill_nxt;
  logic                cmp_pending, pending_nxt;
  logic                match_nxt;
  logic [CNT_W-1:0]    count_nxt;
  logic                accept;
  logic                hit;

  assign in_ready = (state != IDLE) && !pat_load;
  assign accept   = in_valid && in_ready;
  assign scanning = (state == SCAN);
  assign cmp_a    = window;
  assign cmp_b    = pattern;

  // A pattern reload on the evaluation edge discards the pre-load window's result.
  assign hit = cmp_pending && cmp_eq && !pat_load;

  always_comb begin
    state_nxt   = state;
    window_nxt  = window;
    pattern_nxt = pattern;
    fill_nxt    = fill_cnt;
    pending_nxt = 1'b0;
    match_nxt   = hit;
    count_nxt   = match_count;

    if (hit && (match_count != {CNT_W{1'b1}})) begin
      count_nxt = match_count + CNT_W'(1);
    end

    if (pat_load) begin
      pattern_nxt = pat_data;
      window_nxt  = '0;
      fill_nxt    = '0;
      state_nxt   = FILL;
    end
`ifndef BIT_WINDOW_SCANNER_OVERLAP_EN
    else if (hit) begin
      // Non-overlapping: restart the fill; a bit offered on this edge is dropped.
      window_nxt = '0;
      fill_nxt   = '0;
      state_nxt  = FILL;
    end
`endif
    else if (accept) begin
      window_nxt = {window[LENGTH-2:0], in_bit};
      case (state)
        FILL: begin
          fill_nxt = fill_cnt + FILL_W'(1);
          if (fill_cnt == FILL_W'(LENGTH - 1)) begin
            state_nxt   = SCAN;
            pending_nxt = 1'b1;
          end
        end
        SCAN:    pending_nxt = 1'b1;
        default: pending_nxt = 1'b0;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      window      <= '0;
      pattern     <= '0;
      fill_cnt    <= '0;
      cmp_pending <= 1'b0;
      match       <= 1'b0;
      match_count <= '0;
    end else begin
      state       <= state_nxt;
      window      <= window_nxt;
      pattern     <= pattern_nxt;
      fill_cnt    <= fill_nxt;
      cmp_pending <= pending_nxt;
      match       <= match_nxt;
      match_count <= count_nxt;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_bit_window_scanner.sv
//==============================================================================
// tb_bit_window_scanner: checks two scanner instances (22/16 and 4/2) against
// a bit-history reference model, directed tables and random traffic.  Rev 1.0
//==============================================================================
`default_nettype none

module tb_bit_window_scanner;

`ifdef BIT_WINDOW_SCANNER_OVERLAP_EN
  localparam bit OVL = 1'b1;
`else
  localparam bit OVL = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  // Instance 0: defaults
  logic v0 = 0, b0 = 0, ld0 = 0, rdy0, eq0, m0, s0;
  logic [21:0] d0 = '0, a0, p0;
  logic [15:0] c0;
  // Instance 1: LENGTH=4, CNT_W=2
  logic v1 = 0, b1 = 0, ld1 = 0, rdy1, eq1, m1, s1;
  logic [3:0] d1 = '0, a1, p1;
  logic [1:0] c1;

  assign eq0 = (a0 == p0);
  assign eq1 = (a1 == p1);

  bit_window_scanner dut0 (
    .clk(clk), .rst(rst), .in_valid(v0), .in_ready(rdy0), .in_bit(b0),
    .pat_load(ld0), .pat_data(d0), .cmp_a(a0), .cmp_b(p0), .cmp_eq(eq0),
    .match(m0), .match_count(c0), .scanning(s0));

  bit_window_scanner #(.LENGTH(4), .CNT_W(2)) dut1 (
    .clk(clk), .rst(rst), .in_valid(v1), .in_ready(rdy1), .in_bit(b1),
    .pat_load(ld1), .pat_data(d1), .cmp_a(a1), .cmp_b(p1), .cmp_eq(eq1),
    .match(m1), .match_count(c1), .scanning(s1));

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference model: last-L-bits value of the accepted stream since the last restart.
  int                L    [2] = '{22, 4};
  longint unsigned   cmax [2] = '{65535, 3};
  bit                m_loaded [2];
  longint unsigned   m_pat [2], m_win [2], m_cnt [2];
  int                m_n [2];
  bit                m_due [2], m_match [2];

  function automatic longint unsigned mask(input int k);
    return (64'd1 << L[k]) - 64'd1;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_loaded[k] = 0; m_pat[k] = 0; m_win[k] = 0; m_cnt[k] = 0;
      m_n[k] = 0; m_due[k] = 0; m_match[k] = 0;
    end
  endtask

  task automatic model_step(input int k, input bit v, input bit b, input bit ld,
                            input longint unsigned d);
    bit acc, hit;
    acc = v && m_loaded[k] && !ld;
    hit = m_due[k] && (m_win[k] == m_pat[k]) && !ld;
    m_match[k] = hit;
    if (hit && m_cnt[k] < cmax[k]) m_cnt[k]++;
    if (ld) begin
      m_pat[k] = d & mask(k); m_win[k] = 0; m_n[k] = 0; m_loaded[k] = 1; m_due[k] = 0;
    end else if (hit && !OVL) begin
      m_win[k] = 0; m_n[k] = 0; m_due[k] = 0;
    end else if (acc) begin
      m_win[k] = (m_win[k] * 2 + longint'(b)) & mask(k);
      if (m_n[k] < L[k]) m_n[k]++;
      m_due[k] = (m_n[k] == L[k]);
    end else begin
      m_due[k] = 0;
    end
  endtask

  task automatic tick();
    #1;
    chk("ready0", rdy0, m_loaded[0] && !ld0);
    chk("ready1", rdy1, m_loaded[1] && !ld1);
    model_step(0, v0, b0, ld0, d0);
    model_step(1, v1, b1, ld1, d1);
    @(posedge clk);
    #1;
    chk("match0", m0, m_match[0]);
    chk("count0", c0, m_cnt[0]);
    chk("scan0",  s0, m_loaded[0] && m_n[0] == L[0]);
    chk("cmp_a0", a0, m_win[0]);
    chk("cmp_b0", p0, m_pat[0]);
    chk("match1", m1, m_match[1]);
    chk("count1", c1, m_cnt[1]);
    chk("scan1",  s1, m_loaded[1] && m_n[1] == L[1]);
    chk("cmp_a1", a1, m_win[1]);
    chk("cmp_b1", p1, m_pat[1]);
  endtask

  task automatic set0(input logic v, input logic b, input logic ld, input logic [21:0] d);
    v0 = v; b0 = b; ld0 = ld; d0 = d;
  endtask

  task automatic set1(input logic v, input logic b, input logic ld, input logic [3:0] d);
    v1 = v; b1 = b; ld1 = ld; d1 = d;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    #1;
    chk("rst_ready", rdy0, 1'b0);
    chk("rst_cmp_a", a0, 22'h0);
    chk("rst_cmp_b", p0, 22'h0);
    chk("rst_count", c0, 16'h0);
    chk("rst_scan",  s0, 1'b0);
    chk("rst_match", m0, 1'b0);
    model_reset();
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  typedef struct {
    logic v, b, ld;
    logic [3:0] d;
    logic rdy;
    logic [3:0] a, p;
    logic m, s;
    logic [1:0] c;
  } vec_t;

  function automatic vec_t mk(logic v, logic b, logic ld, logic [3:0] d, logic rdy,
                              logic [3:0] a, logic [3:0] p, logic m, logic s, logic [1:0] c);
    vec_t r;
    r.v = v; r.b = b; r.ld = ld; r.d = d; r.rdy = rdy;
    r.a = a; r.p = p; r.m = m; r.s = s; r.c = c;
    return r;
  endfunction

  vec_t tbl [15];
  int   pulses;
  logic [1:0] sat_seen [6];
  logic [21:0] pat;

  initial begin
    //                v  b  ld d     rdy a               p     m  s     c
    tbl[0]  = mk(1, 1, 0, 4'h0, 0, 4'h0,           4'h0, 0, 0,     2'd0);
    tbl[1]  = mk(0, 0, 1, 4'hA, 0, 4'h0,           4'hA, 0, 0,     2'd0);
    tbl[2]  = mk(1, 1, 0, 4'h0, 1, 4'h1,           4'hA, 0, 0,     2'd0);
    tbl[3]  = mk(1, 0, 0, 4'h0, 1, 4'h2,           4'hA, 0, 0,     2'd0);
    tbl[4]  = mk(1, 1, 0, 4'h0, 1, 4'h5,           4'hA, 0, 0,     2'd0);
    tbl[5]  = mk(1, 0, 0, 4'h0, 1, 4'hA,           4'hA, 0, 1,     2'd0);
    tbl[6]  = mk(0, 0, 0, 4'h0, 1, OVL ? 4'hA : 4'h0, 4'hA, 1, OVL, 2'd1);
    tbl[7]  = mk(0, 0, 0, 4'h0, 1, OVL ? 4'hA : 4'h0, 4'hA, 0, OVL, 2'd1);
    tbl[8]  = mk(1, 1, 1, 4'h1, 0, 4'h0,           4'h1, 0, 0,     2'd1);
    tbl[9]  = mk(1, 0, 0, 4'h0, 1, 4'h0,           4'h1, 0, 0,     2'd1);
    tbl[10] = mk(1, 0, 0, 4'h0, 1, 4'h0,           4'h1, 0, 0,     2'd1);
    tbl[11] = mk(1, 0, 0, 4'h0, 1, 4'h0,           4'h1, 0, 0,     2'd1);
    tbl[12] = mk(1, 1, 0, 4'h0, 1, 4'h1,           4'h1, 0, 1,     2'd1);
    tbl[13] = mk(0, 0, 0, 4'h0, 1, OVL ? 4'h1 : 4'h0, 4'h1, 1, OVL, 2'd2);
    tbl[14] = mk(0, 0, 0, 4'h0, 1, OVL ? 4'h1 : 4'h0, 4'h1, 0, OVL, 2'd2);

    model_reset();
    #2;
    do_reset();

    // Directed table on the small instance
    for (int i = 0; i < 15; i++) begin
      set1(tbl[i].v, tbl[i].b, tbl[i].ld, tbl[i].d);
      #1;
      chk("tbl_ready", rdy1, tbl[i].rdy);
      tick();
      chk("tbl_cmp_a", a1, tbl[i].a);
      chk("tbl_cmp_b", p1, tbl[i].p);
      chk("tbl_match", m1, tbl[i].m);
      chk("tbl_scan",  s1, tbl[i].s);
      chk("tbl_count", c1, tbl[i].c);
    end
    set1(0, 0, 0, 4'h0);

    // Basic match
    pat = 22'h2C5A13;
    set0(0, 0, 1, pat); tick();
    pulses = 0;
    for (int i = 21; i >= 0; i--) begin
      set0(1, pat[i], 0, '0); tick();
      if (m0) pulses++;
    end
    chk("basic_scan", s0, 1'b1);
    for (int i = 0; i < 3; i++) begin
      set0(0, 0, 0, '0); tick();
      if (m0) pulses++;
    end
    chk("basic_pulses", pulses, 1);
    chk("basic_count", c0, 16'd1);

    // Overlap / non-overlap on all ones
    set0(0, 0, 1, 22'h3FFFFF); tick();
    pulses = 0;
    for (int i = 0; i < 24; i++) begin
      set0(1, 1, 0, '0); tick();
      if (m0) pulses++;
    end
    for (int i = 0; i < 2; i++) begin
      set0(0, 0, 0, '0); tick();
      if (m0) pulses++;
    end
    chk("ovl_pulses", pulses, OVL ? 3 : 1);
    chk("ovl_count", c0, OVL ? 16'd4 : 16'd2);

    // Reload collision while scanning
    set0(0, 0, 1, 22'h3FFFFF); tick();
    for (int i = 0; i < 22; i++) begin set0(1, 0, 0, '0); tick(); end
    chk("coll_pre_scan", s0, 1'b1);
    set0(1, 1, 1, 22'h000001);
    #1;
    chk("coll_ready", rdy0, 1'b0);
    tick();
    chk("coll_scan", s0, 1'b0);
    chk("coll_cmp_b", p0, 22'h000001);
    chk("coll_cmp_a", a0, 22'h0);
    pulses = 0;
    for (int i = 0; i < 22; i++) begin
      set0(1, (i == 21), 0, '0); tick();
      if (m0) pulses++;
    end
    for (int i = 0; i < 2; i++) begin
      set0(0, 0, 0, '0); tick();
      if (m0) pulses++;
    end
    chk("coll_pulses", pulses, 1);

    // Gapped input
    pat = 22'h2C5A13;
    set0(0, 0, 1, pat); tick();
    pulses = 0;
    for (int i = 21; i >= 0; i--) begin
      set0(1, pat[i], 0, '0); tick();
      if (m0) pulses++;
      set0(0, 1'($urandom_range(0, 1)), 0, '0); tick();
      if (m0) pulses++;
    end
    set0(0, 0, 0, '0); tick();
    if (m0) pulses++;
    chk("gap_pulses", pulses, 1);

    // Saturation on the 2-bit counter
    do_reset();
    set1(0, 0, 1, 4'hF); tick();
    pulses = 0;
    for (int i = 0; i < 60 && pulses < 6; i++) begin
      set1(1, 1, 0, 4'h0); tick();
      if (m1) begin sat_seen[pulses] = c1; pulses++; end
    end
    set1(0, 0, 0, 4'h0);
    chk("sat_pulses", pulses, 6);
    for (int i = 0; i < 6; i++) chk("sat_count", sat_seen[i], (i < 3) ? i + 1 : 3);

    // Reset mid-stream in SCAN, then no accepts until a load
    set0(0, 0, 1, 22'h155555); tick();
    for (int i = 0; i < 23; i++) begin set0(1, 1'($urandom_range(0, 1)), 0, '0); tick(); end
    chk("pre_rst_scan", s0, 1'b1);
    set0(1, 1, 0, '0);
    do_reset();
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("post_rst_ready", rdy0, 1'b0);
    end

    // Random traffic against the model
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 199) == 0)
        set0(0, 0, 1, ($urandom_range(0, 1) != 0) ? 22'h0 : 22'($urandom));
      else
        set0($urandom_range(0, 3) != 0, $urandom_range(0, 7) == 0, 0, 22'($urandom));
      if ($urandom_range(0, 39) == 0)
        set1(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1, 4'($urandom));
      else
        set1($urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)), 0, 4'($urandom));
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/bit_window_scanner.md
# bit_window_scanner

Serial pattern-search front end that assembles an incoming bit stream into a LENGTH-bit sliding window and drives it, together with a programmable reference pattern, into the `comparator` equality stage. It consumes the comparator's `eq` result, converts it into a registered match pulse and maintains a saturating match counter. It sits directly upstream of `comparator`, which is instantiated beside it at the parent level.

## Interface
- Clock is `clk` and reset is `rst`. Reset is asynchronous and active-high, with one clock domain.
- Parameters:
  - `LENGTH`, default 22: window and pattern width. Must equal the `comparator` LENGTH. Legal range 2..64.
  - `CNT_W`, default 16: match counter width.
- Ports:
  - `clk`  in  1  rising-edge clock.
  - `rst`  in  1  asynchronous active-high reset.
  - `in_valid`  in  1  `in_bit` is offered this cycle.
  - `in_ready`  out  1  scanner accepts a bit this cycle. Combinational.
  - `in_bit`  in  1  serial data bit.
  - `pat_load`  in  1  single-cycle strobe that loads `pat_data`.
  - `pat_data`  in  LENGTH  new reference pattern.
  - `cmp_a`  out  LENGTH  window register, wired to comparator `a`.
  - `cmp_b`  out  LENGTH  pattern register, wired to comparator `b`.
  - `cmp_eq`  in  1  comparator `eq`, combinational from `cmp_a`/`cmp_b`.
  - `match`  out  1  registered one-cycle match pulse.
  - `match_count`  out  CNT_W  saturating count of matches.
  - `scanning`  out  1  state is SCAN.

## Operation
- States:
  - IDLE: no pattern loaded.
  - FILL: window not yet full.
  - SCAN: window full; every accepted bit yields one compare.
- Accept condition: `in_valid && in_ready`.
- `in_ready` = (state != IDLE) && !`pat_load`.
- On accept, the window shifts: window <= {window[LENGTH-2:0], in_bit}. The oldest bit leaves at the MSB.
- IDLE -> FILL on `pat_load`:
  - pattern <= `pat_data`.
  - window <= 0.
  - fill counter <= 0.
  - `match_count` is not cleared.
- FILL:
  - Each accept increments the fill counter (width $clog2(LENGTH+1)).
  - The accept that brings the count to LENGTH moves the state to SCAN and sets `cmp_pending`.
- SCAN: each accept sets `cmp_pending`. With no accept, `cmp_pending` clears.
- Evaluation: on the edge after `cmp_pending` is set:
  - `match` <= `cmp_pending && cmp_eq`.
  - If a match occurs, `match_count` increments unless it equals 2^CNT_W-1, in which case it holds (saturates).
- `pat_load` in FILL or SCAN:
  - Reloads the pattern, clears the window, clears the fill counter and clears `cmp_pending`.
  - Goes to FILL.
  - No `match` is produced from the pre-load window.
- If `pat_load` and `in_valid` occur in the same cycle, `pat_load` wins and the bit is not accepted (`in_ready` is low).
- Reset mid-operation: all registers return to reset values immediately, the pattern is lost and the state is IDLE.

## Timing
- Reset values: `in_ready` 0, `cmp_a` 0, `cmp_b` 0, `match` 0, `match_count` 0, `scanning` 0, state IDLE, fill counter 0, `cmp_pending` 0.
- Pattern load at edge P:
  - `cmp_b` holds the new pattern from P onward.
  - `in_ready` can be high in the cycle after P.
- Latency: a bit accepted at edge N gives `cmp_a` updated after N. `cmp_eq` settles in that cycle. `match` is high for exactly one cycle after edge N+1.
- `match_count` updates on the same edge as `match` rises.
- Throughput: one bit per cycle, with no bubbles in SCAN.
- Back-to-back accepts produce back-to-back `match` pulses when each window matches.
- `cmp_eq` is sampled only when `cmp_pending` is 1. Its value at other times is ignored.

## Configuration
- Macro `BIT_WINDOW_SCANNER_OVERLAP_EN`.
- Defined: matches may overlap. Scanning continues in SCAN after a match, so a window can match on consecutive bits.
- Undefined: non-overlapping mode. On the edge a match is registered:
  - window <= 0.
  - fill counter <= 0.
  - state <= FILL.
  - The next match therefore needs LENGTH fresh bits.
  - Any bit accepted on that same edge is discarded.
  - `match_count` still increments normally.

## Test plan
- Reset check, LENGTH=22: assert `rst` mid-stream in SCAN -> `in_ready`=0, `cmp_a`=0, `cmp_b`=0, `match_count`=0, `scanning`=0 in the same cycle. After release, no accept until `pat_load`.
- Basic match: load 22'h2C5A13, then stream its 22 bits MSB-first with `in_valid` held high -> `scanning` rises after bit 22 is accepted. `match` pulses exactly once, one cycle after edge N+1. `match_count`=1.
- Overlap, pattern 22'h3FFFFF, 24 consecutive ones:
  - With the macro: 3 `match` pulses on consecutive cycles, `match_count`=3.
  - Without the macro: 1 pulse, `match_count`=1.
- Reload collision: assert `pat_load` (22'h000001) together with `in_valid` in SCAN -> `in_ready`=0, the bit is dropped, the state is FILL and `cmp_b`=22'h000001. A stream of 21 zeros then a one gives a single match.
- Saturation, `CNT_W`=2, overlap build, 6 matching windows -> `match_count` reads 1,2,3,3,3,3, and `match` pulses every time.
- Gapped input: toggle `in_valid` 1,0,1,0 while streaming a matching pattern -> `match` occurs only one cycle after the accept edge + 1. No pulse occurs in idle-input cycles.
